pong_renderer_pipe: RTL and testbench

PONG_RENDERER_PIPE -- requirements
Module: pong_renderer_pipe

---
 rtl/pong_renderer_pipe.sv | 153 +++++++++++++++
 tb/tb_pong_renderer_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pong_renderer_pipe.sv
// Two-stage Pong pixel renderer: frame-coherent object hit tests, midline dashes,
// offscreen blanking and a frame-counted colour-inversion flash.
module pong_renderer_pipe #(
    parameter int unsigned COORD_W      = 10,
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned BALL_SIZE    = 10,
    parameter int unsigned PADDLE_W     = 10,
    parameter int unsigned PADDLE_H     = 60,
    parameter int unsigned PADDLEL_X    = 3,
    parameter int unsigned PADDLER_X    = 630,
    parameter int unsigned MID_W        = 4,
    parameter int unsigned DASH_LOG2    = 5,
    parameter logic [23:0] FG_COLOR     = 24'h000000,
    parameter logic [23:0] BG_COLOR     = 24'hFFFFFF,
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_valid,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    input  logic [COORD_W-1:0] paddleL_y,
    input  logic [COORD_W-1:0] paddleR_y,
    input  logic               flash_req,
    output logic               out_valid,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [23:0]        out_color,
    output logic               flash_active
);

    localparam int unsigned UW      = COORD_W + 1;
    localparam int unsigned FLASH_W = $clog2(FLASH_FRAMES + 1);

    logic [COORD_W-1:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [COORD_W-1:0] padl_y_q, padl_y_d, padr_y_q, padr_y_d;
    logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;

    logic s1_ball_q, s1_ball_d, s1_padl_q, s1_padl_d, s1_padr_q, s1_padr_d;
    logic s1_mid_q, s1_mid_d, s1_off_q, s1_off_d, s1_flash_q, s1_flash_d;
    logic s1_valid_q, s1_valid_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;

    logic        out_valid_q, out_valid_d, hsync_out_q, hsync_out_d;
    logic        vsync_out_q, vsync_out_d;
    logic [23:0] out_color_q, out_color_d;

    logic               fs, hit;
    logic [UW-1:0]      xe, ye, bx, by, ply, pry;
    logic [23:0]        fg, bg;

    // Stage 1: hit tests. Bounds are evaluated in COORD_W+1 bits so pos+size never wraps.
    always_comb begin
        fs  = pix_valid && (x == '0) && (y == '0);
        xe  = {1'b0, x};
        ye  = {1'b0, y};
        bx  = {1'b0, fs ? ball_x    : ball_x_q};
        by  = {1'b0, fs ? ball_y    : ball_y_q};
        ply = {1'b0, fs ? paddleL_y : padl_y_q};
        pry = {1'b0, fs ? paddleR_y : padr_y_q};

        ball_x_d = fs ? ball_x    : ball_x_q;
        ball_y_d = fs ? ball_y    : ball_y_q;
        padl_y_d = fs ? paddleL_y : padl_y_q;
        padr_y_d = fs ? paddleR_y : padr_y_q;

        flash_cnt_d = flash_cnt_q;
        if (flash_req)
            flash_cnt_d = FLASH_W'(FLASH_FRAMES);
        else if (fs && (flash_cnt_q != '0))
            flash_cnt_d = flash_cnt_q - FLASH_W'(1);

        s1_ball_d  = (bx <= xe) && (xe < bx + UW'(BALL_SIZE)) &&
                     (by <= ye) && (ye < by + UW'(BALL_SIZE));
        s1_padl_d  = (UW'(PADDLEL_X) <= xe) && (xe < UW'(PADDLEL_X + PADDLE_W)) &&
                     (ply <= ye) && (ye < ply + UW'(PADDLE_H));
        s1_padr_d  = (UW'(PADDLER_X) <= xe) && (xe < UW'(PADDLER_X + PADDLE_W)) &&
                     (pry <= ye) && (ye < pry + UW'(PADDLE_H));
        s1_mid_d   = (UW'(SCREEN_W/2 - MID_W/2) <= xe) && (xe < UW'(SCREEN_W/2 + MID_W/2)) &&
                     !y[DASH_LOG2-1];
        s1_off_d   = (xe >= UW'(SCREEN_W)) || (ye >= UW'(SCREEN_H));
        s1_flash_d = (flash_cnt_q != '0);
        s1_valid_d = pix_valid;
        s1_hs_d    = hsync_in;
        s1_vs_d    = vsync_in;
    end

    // Stage 2: colour selection; offscreen and invalid pixels are forced black.
    always_comb begin
        hit = s1_ball_q || s1_padl_q || s1_padr_q || s1_mid_q;
        fg  = s1_flash_q ? BG_COLOR : FG_COLOR;
        bg  = s1_flash_q ? FG_COLOR : BG_COLOR;
        out_color_d = '0;
        if (s1_valid_q && !s1_off_q)
            out_color_d = hit ? fg : bg;
        out_valid_d = s1_valid_q;
        hsync_out_d = s1_hs_q;
        vsync_out_d = s1_vs_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ball_x_q    <= COORD_W'(SCREEN_W / 2);
            ball_y_q    <= COORD_W'(SCREEN_H / 2);
            padl_y_q    <= COORD_W'((SCREEN_H - PADDLE_H) / 2);
            padr_y_q    <= COORD_W'((SCREEN_H - PADDLE_H) / 2);
            flash_cnt_q <= '0;
            s1_ball_q   <= 1'b0;
            s1_padl_q   <= 1'b0;
            s1_padr_q   <= 1'b0;
            s1_mid_q    <= 1'b0;
            s1_off_q    <= 1'b0;
            s1_flash_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_hs_q     <= 1'b0;
            s1_vs_q     <= 1'b0;
            out_valid_q <= 1'b0;
            hsync_out_q <= 1'b0;
            vsync_out_q <= 1'b0;
            out_color_q <= '0;
        end else begin
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            padl_y_q    <= padl_y_d;
            padr_y_q    <= padr_y_d;
            flash_cnt_q <= flash_cnt_d;
            s1_ball_q   <= s1_ball_d;
            s1_padl_q   <= s1_padl_d;
            s1_padr_q   <= s1_padr_d;
            s1_mid_q    <= s1_mid_d;
            s1_off_q    <= s1_off_d;
            s1_flash_q  <= s1_flash_d;
            s1_valid_q  <= s1_valid_d;
            s1_hs_q     <= s1_hs_d;
            s1_vs_q     <= s1_vs_d;
            out_valid_q <= out_valid_d;
            hsync_out_q <= hsync_out_d;
            vsync_out_q <= vsync_out_d;
            out_color_q <= out_color_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign hsync_out    = hsync_out_q;
    assign vsync_out    = vsync_out_q;
    assign out_color    = out_color_q;
    assign flash_active = (flash_cnt_q != '0);

endmodule

// File: tb/tb_pong_renderer_pipe.sv
// Scoreboard bench for pong_renderer_pipe: directed pixels push expected colour/syncs,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_pong_renderer_pipe;

    localparam int unsigned CW = 10;
    localparam logic [23:0] BLK = 24'h000000;
    localparam logic [23:0] WHT = 24'hFFFFFF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pix_valid = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, flash_req = 1'b0;
    logic [CW-1:0] x = '0, y = '0;
    logic [CW-1:0] ball_x = '0, ball_y = '0, paddleL_y = '0, paddleR_y = '0;
    logic          out_valid, hsync_out, vsync_out, flash_active;
    logic [23:0]   out_color;

    typedef struct {
        logic [23:0] col;
        logic        hs;
        logic        vs;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    pong_renderer_pipe #(.COORD_W(CW), .FLASH_FRAMES(8)) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .x(x), .y(y), .ball_x(ball_x), .ball_y(ball_y),
        .paddleL_y(paddleL_y), .paddleR_y(paddleR_y), .flash_req(flash_req),
        .out_valid(out_valid), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .out_color(out_color), .flash_active(flash_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got color %h, expected no output", out_color);
                end else begin
                    mon_e = q.pop_front();
                    check("color", 32'(out_color), 32'(mon_e.col));
                    check("hsync", 32'(hsync_out), 32'(mon_e.hs));
                    check("vsync", 32'(vsync_out), 32'(mon_e.vs));
                    check("latency", cyc - mon_e.cyc, 32'd2);
                end
            end else begin
                check("idle_color", 32'(out_color), 32'd0);
            end
        end
    end

    task automatic pix(input int unsigned px, input int unsigned py, input logic hs,
                       input logic vs, input logic [23:0] col, input logic req = 1'b0);
        exp_t e;
        @(negedge clk);
        pix_valid = 1'b1;
        x = CW'(px);
        y = CW'(py);
        hsync_in = hs;
        vsync_in = vs;
        flash_req = req;
        e.col = col;
        e.hs = hs;
        e.vs = vs;
        e.cyc = cyc;
        q.push_back(e);
    endtask

    task automatic idle(input logic req = 1'b0);
        @(negedge clk);
        pix_valid = 1'b0;
        flash_req = req;
        x = CW'(7);
        y = CW'(7);
    endtask

    // One tiny frame: fs pixel, background, left-paddle hit, offscreen ball hit.
    task automatic frame(input logic f_fs, input logic f_rest, input logic req = 1'b0);
        pix(0, 0, 1'b0, 1'b1, f_fs ? BLK : WHT, req);
        check("flash_active_fs", 32'(flash_active), 32'(f_fs));
        pix(50, 100, 1'b1, 1'b0, f_rest ? BLK : WHT);
        check("flash_active_rest", 32'(flash_active), 32'(f_rest));
        pix(5, 240, 1'b0, 1'b0, f_rest ? WHT : BLK);
        pix(1021, 5, 1'b1, 1'b1, BLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        paddleL_y = CW'(210);
        paddleR_y = CW'(210);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_color", 32'(out_color), 32'd0);
        check("rst_hsync", 32'(hsync_out), 32'd0);
        check("rst_vsync", 32'(vsync_out), 32'd0);
        check("rst_flash", 32'(flash_active), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // shadows hold reset positions: ball at 320,240 and paddles at y=210
        pix(325, 245, 1'b1, 1'b0, BLK);
        pix(5, 215, 1'b0, 1'b1, BLK);
        pix(400, 100, 1'b1, 1'b1, WHT);

        // frame coherence: ball moves after fs but the shadow keeps 100,50
        ball_x = CW'(100);
        ball_y = CW'(50);
        pix(0, 0, 1'b0, 1'b1, WHT);
        @(posedge clk);
        #1 ball_x = CW'(300);
        pix(105, 55, 1'b0, 1'b0, BLK);
        pix(305, 55, 1'b1, 1'b0, WHT);

        // midline dashes
        pix(320, 16, 1'b0, 1'b0, WHT);
        pix(320, 15, 1'b1, 1'b0, BLK);
        pix(322, 5, 1'b0, 1'b1, WHT);
        pix(318, 0, 1'b0, 1'b0, BLK);
        pix(317, 0, 1'b0, 1'b0, WHT);

        // no wrap of ball bound, offscreen blanking
        ball_x = CW'(1020);
        ball_y = CW'(0);
        pix(0, 0, 1'b0, 1'b1, WHT);
        pix(2, 5, 1'b0, 1'b0, WHT);
        pix(700, 10, 1'b1, 1'b0, BLK);
        pix(639, 479, 1'b0, 1'b0, WHT);
        pix(640, 0, 1'b0, 1'b0, BLK);
        pix(0, 480, 1'b0, 1'b0, BLK);

        // flash for exactly 8 frames
        frame(1'b0, 1'b0);
        idle(1'b1);
        repeat (7) frame(1'b1, 1'b1);
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);

        // retrigger coincident with fs of frame 5: reloads to 8, no decrement
        idle(1'b1);
        repeat (4) frame(1'b1, 1'b1);
        frame(1'b1, 1'b1, 1'b1);
        repeat (7) frame(1'b1, 1'b1);
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);

        // reset mid-line while a flash is running and the pipe is full
        idle(1'b1);
        pix(10, 20, 1'b1, 1'b0, BLK);
        pix(11, 20, 1'b0, 1'b1, BLK);
        #7;
        reset = 1'b1;
        q.delete();
        pix_valid = 1'b0;
        flash_req = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_color", 32'(out_color), 32'd0);
        check("midrst_flash", 32'(flash_active), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pix(400, 100, 1'b1, 1'b0, WHT);
        pix(325, 245, 1'b0, 1'b1, BLK);
        pix(5, 215, 1'b1, 1'b1, BLK);

        repeat (4) idle();
        check("drain_queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
